// File: rtl/circ_buffer_ctrl_pkg.sv
// Shared types and width helpers for the circular column buffer controller.
package circ_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    function automatic int unsigned ptr_width(input int unsigned columns);
        return $clog2(columns);
    endfunction

    function automatic int unsigned count_width(input int unsigned columns);
        return $clog2(columns + 1);
    endfunction

endpackage

// File: rtl/circ_buffer_ctrl_if.sv
// Producer/consumer handshake and buffer-side control bundle for circ_buffer_ctrl.
interface circ_buffer_ctrl_if
    import circ_buffer_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS = 32
);
    localparam int unsigned AW = ptr_width(COLUMNS);
    localparam int unsigned CW = count_width(COLUMNS);

    logic          start;
    logic          stop;
    logic          wr_valid;
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_valid;
    logic          write_en;
    logic          read_en;
    logic [AW-1:0] write_ptr;
    logic [AW-1:0] read_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;

    modport master (
        output start, stop, wr_valid, rd_ready,
        input  wr_ready, rd_valid, write_en, read_en, write_ptr, read_ptr, count, full, empty,
               busy
    );

    modport slave (
        input  start, stop, wr_valid, rd_ready,
        output wr_ready, rd_valid, write_en, read_en, write_ptr, read_ptr, count, full, empty,
               busy
    );

endinterface

// File: rtl/circ_ptr_advance.sv
// Wrap-around column pointer: advances by STEP per strobe with exact modulo-COLUMNS wrap.
module circ_ptr_advance
    import circ_buffer_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS = 32,
    parameter int unsigned STEP    = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_clear,
    input  logic                            i_advance,
    output logic [ptr_width(COLUMNS)-1:0]   o_ptr
);
    localparam int unsigned AW = ptr_width(COLUMNS);
    localparam logic [AW:0] ColsW = (AW+1)'(COLUMNS);
    localparam logic [AW:0] StepW = (AW+1)'(STEP);

    logic [AW-1:0] r_ptr;
    logic [AW:0]   w_sum;
    logic [AW:0]   w_wrapped;
    logic          w_unused_msb;

    // One extra bit so ptr+STEP never aliases before the wrap compare.
    always_comb begin
        w_sum     = {1'b0, r_ptr} + StepW;
        w_wrapped = (w_sum >= ColsW) ? (w_sum - ColsW) : w_sum;
    end

    assign w_unused_msb = w_wrapped[AW];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_wrapped[AW-1:0];
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/circ_buffer_ctrl.sv
// Circular column buffer controller: run/drain schedule, occupancy count and handshakes.
module circ_buffer_ctrl
    import circ_buffer_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS   = 32,
    parameter int unsigned PAR_WRITE = 4,
    parameter int unsigned PAR_READ  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    circ_buffer_ctrl_if.slave bus
);
    localparam int unsigned AW = ptr_width(COLUMNS);
    localparam int unsigned CW = count_width(COLUMNS);
    localparam logic [CW:0] ColsW = (CW+1)'(COLUMNS);
    localparam logic [CW:0] PwW   = (CW+1)'(PAR_WRITE);
    localparam logic [CW:0] PrW   = (CW+1)'(PAR_READ);

    state_e        r_state;
    logic [CW-1:0] r_count;

    logic          w_wr_ready;
    logic          w_rd_valid;
    logic          w_write_en;
    logic          w_read_en;
    logic          w_clear;
    logic [CW:0]   w_count_ext;
    logic [CW:0]   w_count_nxt;
    logic          w_unused_msb;
    logic [AW-1:0] w_write_ptr;
    logic [AW-1:0] w_read_ptr;

    // Handshakes depend only on registered state, never on the partner's valid/ready.
    always_comb begin
        w_count_ext = {1'b0, r_count};
        w_wr_ready  = (r_state == StRun) && ((ColsW - w_count_ext) >= PwW);
        w_rd_valid  = (r_state != StIdle) && (w_count_ext >= PrW);
        w_write_en  = bus.wr_valid && w_wr_ready;
        w_read_en   = w_rd_valid && bus.rd_ready;
        w_count_nxt = w_count_ext + (w_write_en ? PwW : '0) - (w_read_en ? PrW : '0);
        // Unreadable remainder (incl. zero) ends the drain and is discarded.
        w_clear     = (r_state == StDrain) && (w_count_ext < PrW);
    end

    assign w_unused_msb = w_count_nxt[CW];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_count <= '0;
        end else begin
            case (r_state)
                StIdle:  if (bus.start) r_state <= StRun;
                StRun:   if (bus.stop) r_state <= StDrain;
                StDrain: if (w_clear) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
            r_count <= w_clear ? '0 : w_count_nxt[CW-1:0];
        end
    end

    circ_ptr_advance #(
        .COLUMNS (COLUMNS),
        .STEP    (PAR_WRITE)
    ) u_wr_ptr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .i_advance (w_write_en),
        .o_ptr     (w_write_ptr)
    );

    circ_ptr_advance #(
        .COLUMNS (COLUMNS),
        .STEP    (PAR_READ)
    ) u_rd_ptr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .i_advance (w_read_en),
        .o_ptr     (w_read_ptr)
    );

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.write_en  = w_write_en;
    assign bus.read_en   = w_read_en;
    assign bus.write_ptr = w_write_ptr;
    assign bus.read_ptr  = w_read_ptr;
    assign bus.count     = r_count;
    assign bus.full      = (r_count == ColsW[CW-1:0]);
    assign bus.empty     = (r_count == '0);
    assign bus.busy      = (r_state != StIdle);

endmodule
